// File: rtl/dc_axi_rd_master_if.sv
// AXI4 read-address and read-data channel bundle used by the data-cache line-fill master.
// Signals: AR channel (arid, araddr, arlen, arsize, arburst, arvalid/arready),
//          R channel (rdata, rresp, rlast, rvalid/rready). rid is not carried (not checked).
interface dc_axi_rd_master_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dc_axi_rd_master.sv
// Purpose : D-cache line fill; one AXI4 INCR burst of 4x32b beats assembled into a 128b line.
// Latency : request -> arvalid next cycle; line pulse the cycle after the 4th beat (or timeout).
// Backpr. : one outstanding fill; requests while busy are dropped; AR stall unbounded, R gaps watchdogged.
// Ports   : clk, rst_n (sync, active low); dcr_start_rq/dcr_rin_addr from the LSU miss FSM;
//           rdat_m_data/rdat_m_valid/finish_mrd/busy/rd_err back to the LSU and cache RAM;
//           axi (master modport) carries the AR and R channels.
module dc_axi_rd_master #(
  parameter int ID_W    = 4,
  parameter int ARID_V  = 0,
  parameter int TMO_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dcr_start_rq,
  input  logic [31:0]           dcr_rin_addr,
  output logic [127:0]          rdat_m_data,
  output logic                  rdat_m_valid,
  output logic                  finish_mrd,
  output logic                  busy,
  output logic                  rd_err,
  dc_axi_rd_master_if.master    axi
);

  // tmo only has to reach TMO_CYC-1; abort is taken on the TMO_CYC-th consecutive idle cycle.
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       araddr_q;
  logic [1:0]        beat;
  logic [TMO_W-1:0]  tmo;
  logic              tmo_hit;
  logic              last_beat;
  logic              unused_addr_lsb;

  // Line offset bits are irrelevant: the fill always starts at the line base.
  assign unused_addr_lsb = ^dcr_rin_addr[3:0];

  assign tmo_hit   = (TMO_CYC != 0) && (tmo == TMO_LIM) && !axi.rvalid;
  assign last_beat = (beat == 2'd3);

  // Fixed burst shape: 4 beats, 4 bytes each, incrementing.
  assign axi.arid    = ID_W'(ARID_V);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'd3;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (dcr_start_rq) state_nxt = S_ADDR;
      S_ADDR: if (axi.arready) state_nxt = S_DATA;
      S_DATA: begin
        // Early rlast is flagged but never ends the burst; only the 4th beat completes it.
        if (axi.rvalid && last_beat) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    rdat_m_valid = 1'b0;
    finish_mrd   = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: busy = 1'b0;
      S_ADDR: axi.arvalid = 1'b1;
      S_DATA: axi.rready = 1'b1;
      S_DONE: begin
        rdat_m_valid = 1'b1;
        finish_mrd   = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath: address latch, line assembly, beat/timeout counters, sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      araddr_q    <= 32'h0;
      rdat_m_data <= 128'h0;
      beat        <= 2'd0;
      tmo         <= '0;
      rd_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dcr_start_rq) begin
            araddr_q    <= {dcr_rin_addr[31:4], 4'h0};
            rdat_m_data <= 128'h0;
            beat        <= 2'd0;
          end
        end
        S_ADDR: begin
          if (axi.arready) begin
            tmo <= '0;
          end
        end
        S_DATA: begin
          if (axi.rvalid) begin
            rdat_m_data[{beat, 5'b0} +: 32] <= axi.rdata;
            beat <= beat + 2'd1;
            tmo  <= '0;
            if ((axi.rresp != 2'b00) || (last_beat != axi.rlast)) begin
              rd_err <= 1'b1;
            end
          end else if (tmo_hit) begin
            rd_err <= 1'b1;
          end else if (TMO_CYC != 0) begin
            tmo <= tmo + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_axi_rd_master.sv
// Directed bench for dc_axi_rd_master (watchdog shortened to 8 cycles).
module tb_dc_axi_rd_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dcr_start_rq;
  logic [31:0]  dcr_rin_addr;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         busy;
  logic         rd_err;

  int n_vec = 0;
  int n_err = 0;

  dc_axi_rd_master_if #(.ID_W(4)) axi ();

  dc_axi_rd_master #(
    .ID_W    (4),
    .ARID_V  (0),
    .TMO_CYC (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dcr_start_rq (dcr_start_rq),
    .dcr_rin_addr (dcr_rin_addr),
    .rdat_m_data  (rdat_m_data),
    .rdat_m_valid (rdat_m_valid),
    .finish_mrd   (finish_mrd),
    .busy         (busy),
    .rd_err       (rd_err),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dcr_start_rq = 1'b0;
    dcr_rin_addr = 32'h0;
    axi.arready  = 1'b0;
    axi.rvalid   = 1'b0;
    axi.rdata    = 32'h0;
    axi.rresp    = 2'b00;
    axi.rlast    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Request in the current cycle, AR accepted in the next; returns in the first DATA cycle.
  task automatic issue(input logic [31:0] a);
    dcr_start_rq = 1'b1;
    dcr_rin_addr = a;
    step();
    dcr_start_rq = 1'b0;
    axi.arready  = 1'b1;
    step();
    axi.arready  = 1'b0;
  endtask

  task automatic put_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
    axi.rvalid = 1'b1;
    axi.rdata  = d;
    axi.rresp  = resp;
    axi.rlast  = last;
    step();
    axi.rvalid = 1'b0;
    axi.rresp  = 2'b00;
    axi.rlast  = 1'b0;
  endtask

  // Observes n cycles starting with the current one, counting pulse cycles.
  task automatic collect(input int n, output int nv, output int nf, output logic [127:0] line);
    nv = 0;
    nf = 0;
    line = '0;
    for (int i = 0; i < n; i++) begin
      if (rdat_m_valid) begin
        nv++;
        line = rdat_m_data;
      end
      if (finish_mrd) nf++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int           nv;
    int           nf;
    logic [127:0] line;
    logic [31:0]  d2 [4];

    // ---- reset state ----
    do_reset();
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_valid", rdat_m_valid, 1'b0);
    check("rst_finish", finish_mrd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", rd_err, 1'b0);
    check("rst_data", rdat_m_data, 128'h0);
    check("rst_araddr", axi.araddr, 32'h0);

    // ---- 1: back-to-back burst, cycle-exact latency ----
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_1234;
    step();                                   // cycle 1
    dcr_start_rq = 1'b0;
    check("t1_arvalid_c1", axi.arvalid, 1'b1);
    check("t1_araddr", axi.araddr, 32'h0000_1230);
    check("t1_arlen", axi.arlen, 8'd3);
    check("t1_arsize", axi.arsize, 3'b010);
    check("t1_arburst", axi.arburst, 2'b01);
    check("t1_arid", axi.arid, 4'd0);
    check("t1_busy_c1", busy, 1'b1);
    axi.arready = 1'b1;
    step();                                   // cycle 2
    axi.arready = 1'b0;
    check("t1_rready_c2", axi.rready, 1'b1);
    check("t1_arvalid_c2", axi.arvalid, 1'b0);
    put_beat(32'h11, 2'b00, 1'b0);
    put_beat(32'h22, 2'b00, 1'b0);
    put_beat(32'h33, 2'b00, 1'b0);
    check("t1_valid_c5", rdat_m_valid, 1'b0);
    put_beat(32'h44, 2'b00, 1'b1);            // cycle 6
    check("t1_valid_c6", rdat_m_valid, 1'b1);
    check("t1_finish_c6", finish_mrd, 1'b1);
    check("t1_line", rdat_m_data, 128'h00000044_00000033_00000022_00000011);
    check("t1_err", rd_err, 1'b0);
    check("t1_busy_c6", busy, 1'b1);
    // request during DONE must be dropped
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_5000;
    step();                                   // cycle 7
    dcr_start_rq = 1'b0;
    check("t1_valid_c7", rdat_m_valid, 1'b0);
    check("t1_busy_c7", busy, 1'b0);
    check("t1_line_hold", rdat_m_data, 128'h00000044_00000033_00000022_00000011);
    check("t1_done_req_ignored", axi.arvalid, 1'b0);

    // ---- 2: AR stall 5 cycles, 2-cycle gaps between beats ----
    d2[0] = 32'hA0A0_0001; d2[1] = 32'hB0B0_0002; d2[2] = 32'hC0C0_0003; d2[3] = 32'hD0D0_0004;
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_ABCC;
    step();
    dcr_start_rq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_arvalid_%0d", i), axi.arvalid, 1'b1);
      check($sformatf("t2_araddr_%0d", i), axi.araddr, 32'h0000_ABC0);
      if (i == 5) axi.arready = 1'b1;
      step();
    end
    axi.arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      put_beat(d2[k], 2'b00, (k == 3));
    end
    collect(6, nv, nf, line);
    check("t2_valid_pulses", nv, 1);
    check("t2_finish_pulses", nf, 1);
    check("t2_line", line, {d2[3], d2[2], d2[1], d2[0]});
    check("t2_err", rd_err, 1'b0);

    // ---- 3: SLVERR on beat 2, sticky error ----
    issue(32'h0000_2008);
    put_beat(32'h3000_0000, 2'b00, 1'b0);
    put_beat(32'h3000_0001, 2'b00, 1'b0);
    put_beat(32'h3000_0002, 2'b10, 1'b0);
    check("t3_err_set", rd_err, 1'b1);
    put_beat(32'h3000_0003, 2'b00, 1'b1);
    check("t3_valid", rdat_m_valid, 1'b1);
    check("t3_line", rdat_m_data, 128'h30000003_30000002_30000001_30000000);
    step();
    issue(32'h0000_2100);
    for (int k = 0; k < 4; k++) put_beat(32'h0, 2'b00, (k == 3));
    check("t3_err_sticky", rd_err, 1'b1);

    // ---- 4: early rlast on beat 2 does not end the burst ----
    do_reset();
    issue(32'h0000_4000);
    put_beat(32'h4000_0000, 2'b00, 1'b0);
    put_beat(32'h4000_0001, 2'b00, 1'b0);
    check("t4_err_before", rd_err, 1'b0);
    put_beat(32'h4000_0002, 2'b00, 1'b1);
    check("t4_no_early_done", rdat_m_valid, 1'b0);
    check("t4_err_early_last", rd_err, 1'b1);
    put_beat(32'h4000_0003, 2'b00, 1'b1);
    check("t4_valid", rdat_m_valid, 1'b1);
    check("t4_line", rdat_m_data, 128'h40000003_40000002_40000001_40000000);

    // ---- 5: long AR stall is not watchdogged; R timeout after one beat ----
    do_reset();
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_5550;
    step();
    dcr_start_rq = 1'b0;
    repeat (12) step();
    check("t5_ar_stall_arvalid", axi.arvalid, 1'b1);
    check("t5_ar_stall_err", rd_err, 1'b0);
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    put_beat(32'hCAFE_0001, 2'b00, 1'b0);     // now 1 cycle after the beat
    repeat (7) step();                        // 8th idle cycle: abort decided here
    check("t5_valid_before", rdat_m_valid, 1'b0);
    check("t5_err_before", rd_err, 1'b0);
    check("t5_busy_wait", busy, 1'b1);
    step();
    check("t5_valid_tmo", rdat_m_valid, 1'b1);
    check("t5_err_tmo", rd_err, 1'b1);
    check("t5_line", rdat_m_data, {96'h0, 32'hCAFE_0001});
    step();
    check("t5_busy_after", busy, 1'b0);

    // ---- 6: request during DATA ignored; reset mid-DATA; clean rerun ----
    do_reset();
    issue(32'h0000_3000);
    put_beat(32'h6000_0000, 2'b00, 1'b0);
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_7770;
    put_beat(32'h6000_0001, 2'b00, 1'b0);
    dcr_start_rq = 1'b0;
    put_beat(32'h6000_0002, 2'b00, 1'b0);
    put_beat(32'h6000_0003, 2'b00, 1'b1);
    check("t6_valid", rdat_m_valid, 1'b1);
    check("t6_line", rdat_m_data, 128'h60000003_60000002_60000001_60000000);
    check("t6_araddr_kept", axi.araddr, 32'h0000_3000);
    step();
    check("t6_no_queue", axi.arvalid, 1'b0);
    check("t6_busy_idle", busy, 1'b0);
    issue(32'h0000_4440);
    put_beat(32'h6100_0000, 2'b00, 1'b1);     // early rlast: error before reset
    rst_n = 1'b0;
    step();
    check("t6_rst_rready", axi.rready, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_err", rd_err, 1'b0);
    check("t6_rst_data", rdat_m_data, 128'h0);
    check("t6_rst_araddr", axi.araddr, 32'h0);
    rst_n = 1'b1;
    step();
    issue(32'h0000_5558);
    check("t6_re_araddr", axi.araddr, 32'h0000_5550);
    for (int k = 0; k < 4; k++) put_beat(32'h7000_0000 + k, 2'b00, (k == 3));
    check("t6_re_valid", rdat_m_valid, 1'b1);
    check("t6_re_line", rdat_m_data, 128'h70000003_70000002_70000001_70000000);
    check("t6_re_err", rd_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
